// File: rtl/cs_result_collector.sv
// cs_result_collector
// Qualifies the free-running output Y of the 9-tap smoothing filter against
// the sample-valid strobe, discards warm-up results, tags the last result of
// each frame and buffers accepted results in a ready/valid FIFO.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   x_valid            upstream sample strobe fed to the filter
//   Y[9:0]             filter output, valid the cycle after its sample
//   out_data[9:0]      FIFO head data (registered)
//   out_last           FIFO head is the final result of a frame (registered)
//   out_valid          FIFO non-empty (registered)
//   out_ready          consumer accepts the head when out_valid && out_ready
//   overflow           sticky: a qualified result was dropped on a full FIFO
//   res_count[15:0]    results written to the FIFO since reset (wraps)
module cs_result_collector #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIN   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        x_valid,
  input  logic [9:0]  Y,
  output logic [9:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [15:0] res_count
);

  localparam int unsigned DW = 10;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state;
  logic [3:0]      wc;
  logic            v_d;
  logic            q_d;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [DW:0]     mem [DEPTH];

  logic [3:0]      wc_inc;
  logic            win_now;
  logic            wr;
  logic            last;
  logic            full;
  logic            pop;
  logic            push;
  logic [PW-1:0]   wr_next;
  logic [PW-1:0]   rd_next;
  logic            head_new;

  // Qualification and FIFO control
  always_comb begin
    wc_inc   = (state == IDLE) ? 4'd1 : wc + 4'd1;
    // Sample presented now completes (or extends) a full window
    win_now  = x_valid && ((state == RUN) || (wc_inc == 4'(WIN)));
    wr       = v_d && q_d;
    // Y reflects the previous sample; x_valid low now means it was the frame's last
    last     = wr && !x_valid;
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = out_valid && out_ready;
    push     = wr && (!full || pop);
    wr_next  = wr_ptr + PW'(push);
    rd_next  = rd_ptr + PW'(pop);
    // The entry being written becomes the head when nothing else remains
    head_new = push && (rd_next == wr_ptr);
  end

  // FIFO storage, not reset: validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {last, Y};
  end

  // Warm-up FSM, alignment registers, pointers and registered head
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wc        <= 4'd0;
      v_d       <= 1'b0;
      q_d       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
      res_count <= 16'd0;
    end else begin
      v_d <= x_valid;
      q_d <= win_now;

      case (state)
        IDLE: begin
          if (x_valid) begin
            wc    <= wc_inc;
            state <= (wc_inc == 4'(WIN)) ? RUN : FILL;
          end
        end
        FILL: begin
          if (!x_valid) begin
            wc    <= 4'd0;
            state <= IDLE;
          end else begin
            wc <= wc_inc;
            if (wc_inc == 4'(WIN)) state <= RUN;
          end
        end
        RUN: begin
          if (!x_valid) begin
            wc    <= 4'd0;
            state <= IDLE;
          end
        end
        default: begin
          wc    <= 4'd0;
          state <= IDLE;
        end
      endcase

      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      out_valid <= (wr_next != rd_next);

      // Head register follows the next head; held when empty or stalled
      if (wr_next != rd_next) begin
        if (head_new) begin
          out_data <= Y;
          out_last <= last;
        end else begin
          out_data <= mem[rd_next[AW-1:0]][DW-1:0];
          out_last <= mem[rd_next[AW-1:0]][DW];
        end
      end

      if (wr && full && !pop) overflow <= 1'b1;
      if (push) res_count <= res_count + 16'd1;
    end
  end

endmodule

// File: doc/cs_result_collector.md
# cs_result_collector

Downstream stage of the 9-tap sliding-window smoothing filter. It qualifies the filter's free-running 10-bit output `Y` against the sample-valid strobe fed to the filter. It discards warm-up results, where the window is not yet full, and tags the last result of each contiguous frame. Accepted results are buffered in a FIFO with a ready/valid output port, and the block keeps an overflow flag and a result counter.

## Interface
- `DEPTH`, 16, FIFO entries (power of 2, ≥4); each entry is {last, data[9:0]}
- `WIN`, 9, filter window length; results before the WIN-th sample of a frame are discarded
- `clk` input 1: single clock; all state changes on its rising edge
- `reset` input 1: synchronous, active-high; one clock, reset is synchronous and active-high
- `x_valid` input 1: high in every cycle the upstream presents a sample on the filter's `X`
- `Y` input 10: filter output, combinational from filter registers
- `out_data` output 10: FIFO head data
- `out_last` output 1: FIFO head is the final result of a frame
- `out_valid` output 1: FIFO non-empty
- `out_ready` input 1: consumer accepts head when `out_valid && out_ready`
- `overflow` output 1: sticky; a qualified result was dropped because the FIFO was full
- `res_count` output 16: number of results written to the FIFO since reset, wraps 0xFFFF→0

## Operation
- Alignment: `Y` for the window ending on the sample presented in cycle t is valid during cycle t+1. The block registers `x_valid` into `v_d` and qualifies `Y` only when `v_d`=1.
- Frame: a maximal run of consecutive `x_valid`=1 cycles. A single low cycle ends the frame and restarts warm-up.
- FSM, with 4-bit warm counter `wc`:
  - IDLE: `wc`=0. On `x_valid`=1, go to FILL with `wc`=1.
  - FILL: `wc` increments on each `x_valid`=1. When `wc` reaches WIN, go to RUN. On `x_valid`=0, go to IDLE.
  - RUN: stay while `x_valid`=1. On `x_valid`=0, go to IDLE.
- Write qualifier `wr` = `v_d` && (`wc` reached WIN on the sample now reflected in `Y`).
  - The first write of a frame is the cycle after the WIN-th sample.
  - Frames shorter than WIN samples produce no writes and no `last`.
- Last tag: `last` = `wr` && `x_valid`=0 in the same cycle, meaning the sample that produced this `Y` was the frame's final sample.
- FIFO:
  - Write {last, `Y`} on `wr` when not full, or when full with a simultaneous pop.
  - Pop on `out_valid && out_ready`.
  - If `wr` arrives while full with no pop, drop the entry, set `overflow`, and leave `res_count` unchanged.
  - Pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare.
- `res_count` increments on each successful FIFO write.
- Data width: `Y` is stored unmodified; there is no arithmetic on data.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `overflow`=0, `res_count`=0, FSM=IDLE, `v_d`=0, FIFO empty.
- Latency: from the cycle of the WIN-th `x_valid` to `out_valid`=1 is 2 cycles (1 for filter alignment, 1 for FIFO write).
- Steady state: 1 result/cycle in and out with `out_ready` held high. The FIFO never fills.
- `out_data`/`out_last` are registered FIFO reads. They are stable while `out_valid`=1 and `out_ready`=0.
- Simultaneous push and pop:
  - When empty, the entry appears the next cycle. There is no combinational bypass.
  - When full, both succeed and occupancy is unchanged.
- Reset asserted mid-frame flushes the FIFO and clears all state on that edge. The first cycle after reset counts as IDLE, even if `x_valid`=1 continued; a new frame starts on the next `x_valid`=1.
- `overflow` clears only on `reset`.

## Test plan
- Reset then 12 contiguous samples X=100 into the filter with `out_ready`=1:
  - 4 outputs of 225; first `out_valid` 2 cycles after the 9th sample.
  - Only the 4th output has `out_last`=1; `res_count`=4.
- Frame of 8 samples, 2 idle cycles, then a 9-sample frame:
  - No output for the first frame.
  - Exactly one output, with `out_last`=1, for the second frame.
- 40-sample frame with `out_ready`=0, DEPTH=16:
  - The first 16 of 32 qualified results are stored; `overflow`=1; `res_count`=16.
  - Releasing `out_ready` drains 16 entries in order.
- FIFO held full, then `out_ready`=1 while writes continue: occupancy stays 16, no new `overflow` events, `res_count` increments each cycle.
- Assert `reset` for 1 cycle during RUN with 5 entries buffered: next cycle `out_valid`=0, `res_count`=0, `overflow`=0; warm-up restarts and needs 9 new samples.
- Alternating `out_ready` 1/0 on a 20-sample frame: all 12 results are delivered in order with no loss and no duplicates, and `out_data` is stable during stalls.
